rggen_bus_arbiter: RTL and testbench
====================================

// Module: rggen_bus_arbiter
// PURPOSE
//  Shares one register bus (rggen_bus_if, master modport) between N requesters. Each requester
//  drives a flattened copy of the bus request signals. A round-robin arbiter grants one requester
//  at a time and forwards its transaction unchanged. The response from the slave side is routed back
//  to the granted requester only. The block sits between several host bridges (e.g. CPU and debug
//  port) and a single register block.
// PARAMETERS
//  REQUESTERS    2   number of requesters, >=1
//  ADDRESS_WIDTH 16  bus address width
//  DATA_WIDTH    32  bus data width; strobe width is DATA_WIDTH/8
// PORTS
//  i_clk          in   1                    clock
//  i_rst          in   1                    reset; asynchronous, active-high
//  i_request      in   N                    per-requester request; held high until its o_done
//  i_address      in   N*ADDRESS_WIDTH      per-requester address, requester k at [k*AW +: AW]
//  i_direction    in   N x rggen_direction  per-requester direction
//  i_write_data   in   N*DATA_WIDTH         per-requester write data
//  i_write_strobe in   N*DATA_WIDTH/8       per-requester byte strobes
//  o_done         out  N                    done; pulsed only for the granted requester
//  o_read_done    out  N                    read done; pulsed only for the granted requester
//  o_write_done   out  N                    write done; pulsed only for the granted requester
//  o_read_data    out  DATA_WIDTH           slave read_data broadcast; valid when o_read_done[k]
//  o_status       out  rggen_status         slave status broadcast; valid when o_done[k]
//  bus_if         if   rggen_bus_if.master  shared downstream bus
// BEHAVIOUR
//  State machine:
//  - IDLE: if any i_request is high, latch grant index g and go to BUSY. Otherwise stay in IDLE.
//  - BUSY: bus_if.request = 1. address, direction, write_data and write_strobe are muxed from
//    requester g. When bus_if.done = 1:
//    - o_done[g], o_read_done[g] and o_write_done[g] equal the bus_if done flags in the same cycle
//      (combinational pass-through).
//    - Next state is IDLE and the round-robin pointer is set to g.
//  Latency and throughput:
//  - Request to bus_if.request: exactly 1 cycle.
//  - One IDLE cycle between transactions, so back-to-back grants have at most 50% bus occupancy.
//  Arbitration:
//  - Round-robin: g = first requester with i_request high, searching from ptr+1 upward and wrapping
//    at N-1 -> 0.
//  - Requests that are not granted are held by their masters and see no response.
//  - With N=1 the search is trivial: g = 0 always.
//  Request/response rules:
//  - In IDLE, bus_if.request = 0 and all fields are driven 0.
//  - All o_*done outputs are 0 outside BUSY and for every k != g.
//  - A requester dropping i_request while granted is a protocol violation. The arbiter does not
//    abort: the transaction completes and its done is still issued.
//  - A new request from g in the same cycle as its done is ignored. Arbitration happens only in IDLE.
//  Reset:
//  - State = IDLE, ptr = N-1 (requester 0 wins first), g = 0.
//  - bus_if.request = 0 and all o_*done = 0 immediately on assertion.
//  - A reset asserted in BUSY abandons the transaction. No done is issued.
// STRUCTURE
//  - rggen_direction and rggen_status come from rggen_rtl_pkg. No new package types are added.
//  - Sub-module rggen_round_robin_selector: in = request vector and ptr, out = one-hot grant and
//    binary index (combinational).
//  - State, ptr and g are registers in this module.
// TESTING
//  - Reset, then i_request=2'b01, addr0=0x0010, read; slave done with read_data=0xDEADBEEF, OKAY
//    -> bus_if.request rises 1 cycle after i_request; o_read_done=01; o_read_data=0xDEADBEEF.
//  - i_request=2'b11 held continuously, 4 transactions -> grant order 0,1,0,1; exactly 1 IDLE cycle
//    between grants.
//  - N=3, ptr=1, i_request=3'b101 -> requester 2 granted; next grant is 0.
//  - Requester 1 writes 0x12345678 with strobe 0xF, slave returns SLAVE_ERROR -> o_write_done=10,
//    o_status=SLAVE_ERROR, o_done[0] stays 0.
//  - Reset asserted while in BUSY with the slave stalled -> bus_if.request=0 in the same cycle;
//    no done; after release requester 0 wins first.
//  - Slave holds done low for 5 cycles -> address, direction and data stay stable from the granted
//    requester and no other requester is granted.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types: transfer direction and response status.
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    // Width of a binary index over n items; a single item still needs one bit.
    function automatic int rggen_index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// Register bus between a host-side master and a register block.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                     request;
    logic [ADDRESS_WIDTH-1:0] address;
    rggen_direction           direction;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   write_strobe;
    logic                     done;
    logic                     read_done;
    logic                     write_done;
    logic [BUS_WIDTH-1:0]     read_data;
    rggen_status              status;

    modport master (
        output request, address, direction, write_data, write_strobe,
        input  done, read_done, write_done, read_data, status
    );

    modport slave (
        input  request, address, direction, write_data, write_strobe,
        output done, read_done, write_done, read_data, status
    );
endinterface

// File: rtl/rggen_round_robin_selector.sv
// Combinational round-robin pick: first set request after ptr, wrapping at REQUESTERS-1.
module rggen_round_robin_selector
    import rggen_rtl_pkg::*;
#(
    parameter int REQUESTERS = 2,
    parameter int IW         = rggen_index_width(REQUESTERS)
)(
    input  logic [REQUESTERS-1:0] request,
    input  logic [IW-1:0]         ptr,
    output logic [REQUESTERS-1:0] grant,
    output logic [IW-1:0]         index
);

    logic found_s;
    logic hit_s;
    int   pos_s;

    // Walk ptr+1 .. ptr+REQUESTERS modulo REQUESTERS; the first hit wins.
    always_comb begin
        grant   = '0;
        index   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        pos_s   = 0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            pos_s        = (int'(ptr) + i) % REQUESTERS;
            hit_s        = !found_s && request[pos_s];
            grant[pos_s] = hit_s;
            index        = hit_s ? IW'(pos_s) : index;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin sharing of one register bus between REQUESTERS host bridges;
// the slave response is steered back only to the requester holding the grant.
module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int REQUESTERS    = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
)(
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [REQUESTERS-1:0]                i_request,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]  i_address,
    input  rggen_direction                       i_direction [REQUESTERS],
    input  logic [REQUESTERS*DATA_WIDTH-1:0]     i_write_data,
    input  logic [REQUESTERS*DATA_WIDTH/8-1:0]   i_write_strobe,
    output logic [REQUESTERS-1:0]                o_done,
    output logic [REQUESTERS-1:0]                o_read_done,
    output logic [REQUESTERS-1:0]                o_write_done,
    output logic [DATA_WIDTH-1:0]                o_read_data,
    output rggen_status                          o_status,
    rggen_bus_if.master                          bus_if
);

    localparam int IW = rggen_index_width(REQUESTERS);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                state_r;
    logic [IW-1:0]         ptr_r;
    logic [IW-1:0]         grant_r;
    logic [REQUESTERS-1:0] sel_grant_s;
    logic [IW-1:0]         sel_index_s;
    logic                  busy_s;

    rggen_round_robin_selector #(
        .REQUESTERS (REQUESTERS),
        .IW         (IW)
    ) u_selector (
        .request (i_request),
        .ptr     (ptr_r),
        .grant   (sel_grant_s),
        .index   (sel_index_s)
    );

    // Arbitration only in IDLE; the pointer moves to the winner once its transfer completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= IW'(REQUESTERS - 1);
            grant_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|sel_grant_s) begin
                        grant_r <= sel_index_s;
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus_if.done) begin
                        ptr_r   <= grant_r;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_s = (state_r == ST_BUSY);

    // Forward the granted requester's fields; idle bus is driven to all zeros.
    always_comb begin
        bus_if.request      = busy_s;
        bus_if.address      = busy_s ? i_address[int'(grant_r)*ADDRESS_WIDTH +: ADDRESS_WIDTH]
                                     : {ADDRESS_WIDTH{1'b0}};
        bus_if.direction    = busy_s ? i_direction[grant_r] : RGGEN_READ;
        bus_if.write_data   = busy_s ? i_write_data[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH]
                                     : {DATA_WIDTH{1'b0}};
        bus_if.write_strobe = busy_s ? i_write_strobe[int'(grant_r)*SW +: SW]
                                     : {SW{1'b0}};
    end

    // Done flags pass straight through, but only on the granted lane and only while busy.
    always_comb begin
        o_done                = '0;
        o_read_done           = '0;
        o_write_done          = '0;
        o_done[grant_r]       = busy_s & bus_if.done;
        o_read_done[grant_r]  = busy_s & bus_if.read_done;
        o_write_done[grant_r] = busy_s & bus_if.write_done;
        o_read_data           = bus_if.read_data;
        o_status              = bus_if.status;
    end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter: a 2-requester instance plus a 3-requester instance.
module tb_rggen_bus_arbiter;
    import rggen_rtl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- N=2 instance ----------------
    logic [1:0]     req2   = 2'b00;
    logic [31:0]    addr2  = 32'h0;
    rggen_direction dir2 [2];
    logic [63:0]    wdata2 = 64'h0;
    logic [7:0]     strb2  = 8'h0;
    logic [1:0]     done2, rdone2, wdone2;
    logic [31:0]    rdata2;
    rggen_status    status2;
    rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bus2 ();

    rggen_bus_arbiter #(.REQUESTERS(2), .ADDRESS_WIDTH(16), .DATA_WIDTH(32)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_request(req2), .i_address(addr2), .i_direction(dir2),
        .i_write_data(wdata2), .i_write_strobe(strb2), .o_done(done2), .o_read_done(rdone2),
        .o_write_done(wdone2), .o_read_data(rdata2), .o_status(status2), .bus_if(bus2)
    );

    // ---------------- N=3 instance ----------------
    logic [2:0]     req3   = 3'b000;
    logic [47:0]    addr3  = {16'h0C02, 16'h0C01, 16'h0C00};
    rggen_direction dir3 [3];
    logic [95:0]    wdata3 = 96'h0;
    logic [11:0]    strb3  = 12'h0;
    logic [2:0]     done3, rdone3, wdone3;
    logic [31:0]    rdata3;
    rggen_status    status3;
    rggen_bus_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) bus3 ();

    rggen_bus_arbiter #(.REQUESTERS(3), .ADDRESS_WIDTH(16), .DATA_WIDTH(32)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_request(req3), .i_address(addr3), .i_direction(dir3),
        .i_write_data(wdata3), .i_write_strobe(strb3), .o_done(done3), .o_read_done(rdone3),
        .o_write_done(wdone3), .o_read_data(rdata3), .o_status(status3), .bus_if(bus3)
    );

    task automatic slave2_quiet();
        bus2.done = 1'b0; bus2.read_done = 1'b0; bus2.write_done = 1'b0;
        bus2.read_data = 32'h0; bus2.status = RGGEN_OKAY;
    endtask

    task automatic slave3_quiet();
        bus3.done = 1'b0; bus3.read_done = 1'b0; bus3.write_done = 1'b0;
        bus3.read_data = 32'h0; bus3.status = RGGEN_OKAY;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req2 = 2'b00; req3 = 3'b000;
        slave2_quiet(); slave3_quiet();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus2.request !== 1'b0) begin failures++; $display("FAIL reset_request got=%b exp=0", bus2.request); end
        checks++; if (done2 !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done2); end
        checks++; if (bus2.address !== 16'h0) begin failures++; $display("FAIL reset_address got=%h exp=0000", bus2.address); end
        do_reset();
    endtask

    task automatic test_read();
        @(negedge clk);
        req2 = 2'b01; addr2[15:0] = 16'h0010; dir2[0] = RGGEN_READ;
        #1;
        checks++; if (bus2.request !== 1'b0) begin failures++; $display("FAIL read_req_early got=%b exp=0", bus2.request); end
        @(negedge clk);
        checks++; if (bus2.request !== 1'b1) begin failures++; $display("FAIL read_req_latency got=%b exp=1", bus2.request); end
        checks++; if (bus2.address !== 16'h0010) begin failures++; $display("FAIL read_address got=%h exp=0010", bus2.address); end
        checks++; if (bus2.direction !== RGGEN_READ) begin failures++; $display("FAIL read_direction got=%b exp=0", bus2.direction); end
        bus2.done = 1'b1; bus2.read_done = 1'b1; bus2.read_data = 32'hDEADBEEF; bus2.status = RGGEN_OKAY;
        #1;
        checks++; if (rdone2 !== 2'b01) begin failures++; $display("FAIL read_rdone got=%b exp=01", rdone2); end
        checks++; if (done2 !== 2'b01) begin failures++; $display("FAIL read_done got=%b exp=01", done2); end
        checks++; if (wdone2 !== 2'b00) begin failures++; $display("FAIL read_wdone got=%b exp=00", wdone2); end
        checks++; if (rdata2 !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", rdata2); end
        checks++; if (status2 !== RGGEN_OKAY) begin failures++; $display("FAIL read_status got=%b exp=00", status2); end
        @(negedge clk);
        slave2_quiet(); req2 = 2'b00;
        #1;
        checks++; if (bus2.request !== 1'b0) begin failures++; $display("FAIL read_back_idle got=%b exp=0", bus2.request); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_onehot;
        logic [15:0] exp_addr;
        do_reset();
        @(negedge clk);
        addr2 = {16'h0200, 16'h0100}; dir2[0] = RGGEN_READ; dir2[1] = RGGEN_READ;
        req2 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_onehot = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr   = (i % 2 == 0) ? 16'h0100 : 16'h0200;
            @(negedge clk);
            checks++; if (bus2.request !== 1'b1) begin failures++; $display("FAIL b2b_request[%0d] got=%b exp=1", i, bus2.request); end
            checks++; if (bus2.address !== exp_addr) begin failures++; $display("FAIL b2b_address[%0d] got=%h exp=%h", i, bus2.address, exp_addr); end
            bus2.done = 1'b1; bus2.read_done = 1'b1;
            #1;
            checks++; if (done2 !== exp_onehot) begin failures++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, done2, exp_onehot); end
            @(negedge clk);
            slave2_quiet();
            if (i == 3) req2 = 2'b00;
            #1;
            checks++; if (bus2.request !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap[%0d] got=%b exp=0", i, bus2.request); end
        end
    endtask

    task automatic test_write_error();
        @(negedge clk);
        req2 = 2'b10; addr2[31:16] = 16'h0040; dir2[1] = RGGEN_WRITE;
        wdata2[63:32] = 32'h12345678; strb2[7:4] = 4'hF;
        @(negedge clk);
        checks++; if (bus2.direction !== RGGEN_WRITE) begin failures++; $display("FAIL wr_direction got=%b exp=1", bus2.direction); end
        checks++; if (bus2.write_data !== 32'h12345678) begin failures++; $display("FAIL wr_data got=%h exp=12345678", bus2.write_data); end
        checks++; if (bus2.write_strobe !== 4'hF) begin failures++; $display("FAIL wr_strobe got=%h exp=f", bus2.write_strobe); end
        checks++; if (bus2.address !== 16'h0040) begin failures++; $display("FAIL wr_address got=%h exp=0040", bus2.address); end
        bus2.done = 1'b1; bus2.write_done = 1'b1; bus2.status = RGGEN_SLAVE_ERROR;
        #1;
        checks++; if (wdone2 !== 2'b10) begin failures++; $display("FAIL wr_wdone got=%b exp=10", wdone2); end
        checks++; if (done2 !== 2'b10) begin failures++; $display("FAIL wr_done got=%b exp=10", done2); end
        checks++; if (rdone2 !== 2'b00) begin failures++; $display("FAIL wr_rdone got=%b exp=00", rdone2); end
        checks++; if (status2 !== RGGEN_SLAVE_ERROR) begin failures++; $display("FAIL wr_status got=%b exp=10", status2); end
        @(negedge clk);
        slave2_quiet(); req2 = 2'b00;
    endtask

    task automatic test_stall();
        @(negedge clk);
        addr2 = {16'h0BB0, 16'h0AA0}; dir2[0] = RGGEN_WRITE; dir2[1] = RGGEN_READ;
        wdata2 = {32'h11112222, 32'hCAFEF00D}; strb2 = 8'hF3;
        req2 = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus2.address !== 16'h0AA0 || bus2.write_data !== 32'hCAFEF00D || bus2.direction !== RGGEN_WRITE || bus2.write_strobe !== 4'h3)
                begin failures++; $display("FAIL stall_fields[%0d] got=%h/%h/%b/%h exp=0aa0/cafef00d/1/3", i, bus2.address, bus2.write_data, bus2.direction, bus2.write_strobe); end
            checks++; if (done2 !== 2'b00) begin failures++; $display("FAIL stall_done[%0d] got=%b exp=00", i, done2); end
        end
        bus2.done = 1'b1; bus2.write_done = 1'b1;
        #1;
        checks++; if (done2 !== 2'b01) begin failures++; $display("FAIL stall_final_done got=%b exp=01", done2); end
        @(negedge clk);
        slave2_quiet(); req2 = 2'b00;
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        req2 = 2'b10;
        @(negedge clk);
        checks++; if (bus2.request !== 1'b1 || bus2.address !== 16'h0BB0) begin failures++; $display("FAIL rstbusy_grant got=%b/%h exp=1/0bb0", bus2.request, bus2.address); end
        rst = 1'b1;
        #1;
        checks++; if (bus2.request !== 1'b0) begin failures++; $display("FAIL rstbusy_request got=%b exp=0", bus2.request); end
        checks++; if (done2 !== 2'b00) begin failures++; $display("FAIL rstbusy_done got=%b exp=00", done2); end
        @(negedge clk);
        rst = 1'b0; req2 = 2'b11;
        @(negedge clk);
        checks++; if (bus2.request !== 1'b1 || bus2.address !== 16'h0AA0) begin failures++; $display("FAIL rstbusy_first_winner got=%b/%h exp=1/0aa0", bus2.request, bus2.address); end
        bus2.done = 1'b1;
        #1;
        checks++; if (done2 !== 2'b01) begin failures++; $display("FAIL rstbusy_done0 got=%b exp=01", done2); end
        @(negedge clk);
        slave2_quiet(); req2 = 2'b00;
    endtask

    task automatic test_three_requesters();
        @(negedge clk);
        dir3[0] = RGGEN_READ; dir3[1] = RGGEN_READ; dir3[2] = RGGEN_READ;
        req3 = 3'b010;
        @(negedge clk);
        bus3.done = 1'b1; bus3.read_done = 1'b1;
        #1;
        checks++; if (done3 !== 3'b010) begin failures++; $display("FAIL n3_setup_done got=%b exp=010", done3); end
        @(negedge clk);
        slave3_quiet(); req3 = 3'b101;
        @(negedge clk);
        checks++; if (bus3.address !== 16'h0C02) begin failures++; $display("FAIL n3_wrap_address got=%h exp=0c02", bus3.address); end
        bus3.done = 1'b1; bus3.read_done = 1'b1;
        #1;
        checks++; if (rdone3 !== 3'b100) begin failures++; $display("FAIL n3_wrap_rdone got=%b exp=100", rdone3); end
        @(negedge clk);
        slave3_quiet(); req3 = 3'b001;
        @(negedge clk);
        checks++; if (bus3.address !== 16'h0C00) begin failures++; $display("FAIL n3_next_address got=%h exp=0c00", bus3.address); end
        bus3.done = 1'b1;
        #1;
        checks++; if (done3 !== 3'b001) begin failures++; $display("FAIL n3_next_done got=%b exp=001", done3); end
        @(negedge clk);
        slave3_quiet(); req3 = 3'b000;
    endtask

    initial begin
        dir2[0] = RGGEN_READ; dir2[1] = RGGEN_READ;
        dir3[0] = RGGEN_READ; dir3[1] = RGGEN_READ; dir3[2] = RGGEN_READ;
        slave2_quiet();
        slave3_quiet();
        test_reset();
        test_read();
        test_back_to_back();
        test_write_error();
        test_stall();
        test_reset_busy();
        test_three_requesters();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
